// File: rtl/zynq_axi_pkg.sv
// zynq_axi_pkg: shared FSM state types and static AXI3 field values for the arbiter
package zynq_axi_pkg;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  localparam logic [3:0] AXI_CACHE      = 4'b0011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT       = 3'b000;
endpackage

// File: rtl/zynq_axi_rr_grant.sv
// zynq_axi_rr_grant: 2-way round-robin picker with a last-grant register
// ports: clk_i/rst_ni clock and async active-low reset, req_i request pair,
//        take_i commits the current pick, gnt_o index of the winning requester
module zynq_axi_rr_grant (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o
);
  logic last_q;
  // a tie goes to whoever did not win last time; a lone request always wins
  assign gnt_o = (req_i == 2'b11) ? ~last_q : req_i[1];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= 1'b1;
    else if (take_i) last_q <= gnt_o;
endmodule

// File: rtl/zynq_axi_mem_arbiter.sv
// zynq_axi_mem_arbiter: two AXI requesters share one AXI3 master, separate read/write arbitration
// ports: aclk/aresetn clock and async active-low reset; s0_axi_*/s1_axi_* reduced AXI slave
//        ports (aw/w/b/ar/r); m00_axi_* full AXI3 master port toward memory
module zynq_axi_mem_arbiter
  import zynq_axi_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [addr_width_p-1:0]   s0_axi_awaddr,
  input  logic [3:0]                s0_axi_awlen,
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [data_width_p-1:0]   s0_axi_wdata,
  input  logic [data_width_p/8-1:0] s0_axi_wstrb,
  input  logic                      s0_axi_wlast,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  output logic                      s0_axi_bvalid,
  output logic [1:0]                s0_axi_bresp,
  input  logic                      s0_axi_bready,
  input  logic [addr_width_p-1:0]   s0_axi_araddr,
  input  logic [3:0]                s0_axi_arlen,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [data_width_p-1:0]   s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rlast,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  input  logic [addr_width_p-1:0]   s1_axi_awaddr,
  input  logic [3:0]                s1_axi_awlen,
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [data_width_p-1:0]   s1_axi_wdata,
  input  logic [data_width_p/8-1:0] s1_axi_wstrb,
  input  logic                      s1_axi_wlast,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  output logic                      s1_axi_bvalid,
  output logic [1:0]                s1_axi_bresp,
  input  logic                      s1_axi_bready,
  input  logic [addr_width_p-1:0]   s1_axi_araddr,
  input  logic [3:0]                s1_axi_arlen,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [data_width_p-1:0]   s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rlast,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  output logic [5:0]                m00_axi_awid,
  output logic [addr_width_p-1:0]   m00_axi_awaddr,
  output logic [3:0]                m00_axi_awlen,
  output logic [2:0]                m00_axi_awsize,
  output logic [1:0]                m00_axi_awburst,
  output logic [1:0]                m00_axi_awlock,
  output logic [3:0]                m00_axi_awcache,
  output logic [2:0]                m00_axi_awprot,
  output logic [3:0]                m00_axi_awqos,
  output logic                      m00_axi_awvalid,
  input  logic                      m00_axi_awready,
  output logic [5:0]                m00_axi_wid,
  output logic [data_width_p-1:0]   m00_axi_wdata,
  output logic [data_width_p/8-1:0] m00_axi_wstrb,
  output logic                      m00_axi_wlast,
  output logic                      m00_axi_wvalid,
  input  logic                      m00_axi_wready,
  input  logic [5:0]                m00_axi_bid,
  input  logic [1:0]                m00_axi_bresp,
  input  logic                      m00_axi_bvalid,
  output logic                      m00_axi_bready,
  output logic [5:0]                m00_axi_arid,
  output logic [addr_width_p-1:0]   m00_axi_araddr,
  output logic [3:0]                m00_axi_arlen,
  output logic [2:0]                m00_axi_arsize,
  output logic [1:0]                m00_axi_arburst,
  output logic [1:0]                m00_axi_arlock,
  output logic [3:0]                m00_axi_arcache,
  output logic [2:0]                m00_axi_arprot,
  output logic [3:0]                m00_axi_arqos,
  output logic                      m00_axi_arvalid,
  input  logic                      m00_axi_arready,
  input  logic [5:0]                m00_axi_rid,
  input  logic [data_width_p-1:0]   m00_axi_rdata,
  input  logic [1:0]                m00_axi_rresp,
  input  logic                      m00_axi_rlast,
  input  logic                      m00_axi_rvalid,
  output logic                      m00_axi_rready
);
  localparam logic [2:0] SIZE = 3'($clog2(data_width_p/8));
  w_state_e w_state_q;
  r_state_e r_state_q;
  logic w_gnt_q, r_gnt_q, w_pick, r_pick, w_take, r_take;
  logic w_addr, w_data, w_resp, r_addr, r_data;
  logic unused_ids;
  // return IDs are ignored: responses always go to the current grant holder
  assign unused_ids = ^{m00_axi_bid, m00_axi_rid};
  assign w_take = (w_state_q == W_IDLE) && (s0_axi_awvalid || s1_axi_awvalid);
  assign r_take = (r_state_q == R_IDLE) && (s0_axi_arvalid || s1_axi_arvalid);
  assign w_addr = w_state_q == W_ADDR;
  assign w_data = w_state_q == W_DATA;
  assign w_resp = w_state_q == W_RESP;
  assign r_addr = r_state_q == R_ADDR;
  assign r_data = r_state_q == R_DATA;
  zynq_axi_rr_grant u_w_rr (.clk_i(aclk), .rst_ni(aresetn), .req_i({s1_axi_awvalid, s0_axi_awvalid}), .take_i(w_take), .gnt_o(w_pick));
  zynq_axi_rr_grant u_r_rr (.clk_i(aclk), .rst_ni(aresetn), .req_i({s1_axi_arvalid, s0_axi_arvalid}), .take_i(r_take), .gnt_o(r_pick));
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= 1'b0;
    end else
      case (w_state_q)
        W_IDLE: if (w_take) begin w_state_q <= W_ADDR; w_gnt_q <= w_pick; end
        W_ADDR: if (m00_axi_awvalid && m00_axi_awready) w_state_q <= W_DATA;
        W_DATA: if (m00_axi_wvalid && m00_axi_wready && m00_axi_wlast) w_state_q <= W_RESP;
        W_RESP: if (m00_axi_bvalid && m00_axi_bready) w_state_q <= W_IDLE;
      endcase
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= 1'b0;
    end else
      case (r_state_q)
        R_IDLE:  if (r_take) begin r_state_q <= R_ADDR; r_gnt_q <= r_pick; end
        R_ADDR:  if (m00_axi_arvalid && m00_axi_arready) r_state_q <= R_DATA;
        R_DATA:  if (m00_axi_rvalid && m00_axi_rready && m00_axi_rlast) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
  assign m00_axi_awid    = {5'd0, w_gnt_q};
  assign m00_axi_awaddr  = w_gnt_q ? s1_axi_awaddr : s0_axi_awaddr;
  assign m00_axi_awlen   = w_gnt_q ? s1_axi_awlen : s0_axi_awlen;
  assign m00_axi_awsize  = SIZE;
  assign m00_axi_awburst = AXI_BURST_INCR;
  assign m00_axi_awlock  = 2'b00;
  assign m00_axi_awcache = AXI_CACHE;
  assign m00_axi_awprot  = AXI_PROT;
  assign m00_axi_awqos   = 4'd0;
  assign m00_axi_awvalid = w_addr && (w_gnt_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign s0_axi_awready  = w_addr && !w_gnt_q && m00_axi_awready;
  assign s1_axi_awready  = w_addr && w_gnt_q && m00_axi_awready;
  assign m00_axi_wid     = {5'd0, w_gnt_q};
  assign m00_axi_wdata   = w_gnt_q ? s1_axi_wdata : s0_axi_wdata;
  assign m00_axi_wstrb   = w_gnt_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m00_axi_wlast   = w_gnt_q ? s1_axi_wlast : s0_axi_wlast;
  assign m00_axi_wvalid  = w_data && (w_gnt_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready   = w_data && !w_gnt_q && m00_axi_wready;
  assign s1_axi_wready   = w_data && w_gnt_q && m00_axi_wready;
  assign s0_axi_bvalid   = w_resp && !w_gnt_q && m00_axi_bvalid;
  assign s1_axi_bvalid   = w_resp && w_gnt_q && m00_axi_bvalid;
  assign s0_axi_bresp    = m00_axi_bresp;
  assign s1_axi_bresp    = m00_axi_bresp;
  assign m00_axi_bready  = w_resp && (w_gnt_q ? s1_axi_bready : s0_axi_bready);
  assign m00_axi_arid    = {5'd0, r_gnt_q};
  assign m00_axi_araddr  = r_gnt_q ? s1_axi_araddr : s0_axi_araddr;
  assign m00_axi_arlen   = r_gnt_q ? s1_axi_arlen : s0_axi_arlen;
  assign m00_axi_arsize  = SIZE;
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arlock  = 2'b00;
  assign m00_axi_arcache = AXI_CACHE;
  assign m00_axi_arprot  = AXI_PROT;
  assign m00_axi_arqos   = 4'd0;
  assign m00_axi_arvalid = r_addr && (r_gnt_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign s0_axi_arready  = r_addr && !r_gnt_q && m00_axi_arready;
  assign s1_axi_arready  = r_addr && r_gnt_q && m00_axi_arready;
  assign s0_axi_rvalid   = r_data && !r_gnt_q && m00_axi_rvalid;
  assign s1_axi_rvalid   = r_data && r_gnt_q && m00_axi_rvalid;
  assign s0_axi_rdata    = m00_axi_rdata;
  assign s1_axi_rdata    = m00_axi_rdata;
  assign s0_axi_rresp    = m00_axi_rresp;
  assign s1_axi_rresp    = m00_axi_rresp;
  assign s0_axi_rlast    = m00_axi_rlast;
  assign s1_axi_rlast    = m00_axi_rlast;
  assign m00_axi_rready  = r_data && (r_gnt_q ? s1_axi_rready : s0_axi_rready);
endmodule

// File: tb/tb_zynq_axi_mem_arbiter.sv
// tb_zynq_axi_mem_arbiter: randomized scenario bench with a round-robin/transfer reference model
module tb_zynq_axi_mem_arbiter;
  logic clk = 1'b0;
  logic aresetn;
  logic [1:0] s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr [2], s_araddr [2];
  logic [3:0] s_awlen [2], s_arlen [2];
  logic [63:0] s_wdata [2];
  logic [7:0] s_wstrb [2];
  wire [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  wire [1:0] s_bresp [2], s_rresp [2];
  wire [63:0] s_rdata [2];
  logic m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast;
  logic [5:0] m_bid, m_rid;
  logic [1:0] m_bresp, m_rresp;
  logic [63:0] m_rdata;
  wire [5:0] m00_axi_awid, m00_axi_wid, m00_axi_arid;
  wire [31:0] m00_axi_awaddr, m00_axi_araddr;
  wire [3:0] m00_axi_awlen, m00_axi_awcache, m00_axi_awqos, m00_axi_arlen, m00_axi_arcache, m00_axi_arqos;
  wire [2:0] m00_axi_awsize, m00_axi_awprot, m00_axi_arsize, m00_axi_arprot;
  wire [1:0] m00_axi_awburst, m00_axi_awlock, m00_axi_arburst, m00_axi_arlock;
  wire [63:0] m00_axi_wdata;
  wire [7:0] m00_axi_wstrb;
  wire m00_axi_awvalid, m00_axi_wlast, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready;
  int tests = 0, fails = 0;
  logic rr_w, rr_r;
  logic [63:0] wq [$];

  zynq_axi_mem_arbiter dut (
    .aclk(clk), .aresetn(aresetn),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wlast(s_wlast[0]), .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]),
    .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bready(s_bready[0]),
    .s0_axi_araddr(s_araddr[0]), .s0_axi_arlen(s_arlen[0]), .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]),
    .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rlast(s_rlast[0]), .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wlast(s_wlast[1]), .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]),
    .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bready(s_bready[1]),
    .s1_axi_araddr(s_araddr[1]), .s1_axi_arlen(s_arlen[1]), .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]),
    .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rlast(s_rlast[1]), .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m00_axi_awid(m00_axi_awid), .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen), .m00_axi_awsize(m00_axi_awsize),
    .m00_axi_awburst(m00_axi_awburst), .m00_axi_awlock(m00_axi_awlock), .m00_axi_awcache(m00_axi_awcache), .m00_axi_awprot(m00_axi_awprot),
    .m00_axi_awqos(m00_axi_awqos), .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m_awready),
    .m00_axi_wid(m00_axi_wid), .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb), .m00_axi_wlast(m00_axi_wlast),
    .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m_wready),
    .m00_axi_bid(m_bid), .m00_axi_bresp(m_bresp), .m00_axi_bvalid(m_bvalid), .m00_axi_bready(m00_axi_bready),
    .m00_axi_arid(m00_axi_arid), .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen), .m00_axi_arsize(m00_axi_arsize),
    .m00_axi_arburst(m00_axi_arburst), .m00_axi_arlock(m00_axi_arlock), .m00_axi_arcache(m00_axi_arcache), .m00_axi_arprot(m00_axi_arprot),
    .m00_axi_arqos(m00_axi_arqos), .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m_arready),
    .m00_axi_rid(m_rid), .m00_axi_rdata(m_rdata), .m00_axi_rresp(m_rresp), .m00_axi_rlast(m_rlast),
    .m00_axi_rvalid(m_rvalid), .m00_axi_rready(m00_axi_rready)
  );

  always #5 clk = ~clk;

  // memory-side view: every beat the master port actually transfers
  always @(negedge clk) if (aresetn && m00_axi_wvalid && m_wready) wq.push_back(m00_axi_wdata);

  function automatic int pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 0 : 1;
    return req[1] ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = '0; s_araddr[i] = '0; s_awlen[i] = '0; s_arlen[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
    end
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    m_bid = '0; m_rid = '0; m_bresp = '0; m_rresp = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    aresetn = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
    rr_w = 1; rr_r = 1;
  endtask

  task automatic write_flow(input int g, input logic [31:0] addr, input logic [3:0] len,
                            input int stall_at, input int stall_n, input logic [5:0] bid);
    logic [63:0] exp_q [$];
    logic [63:0] d;
    logic [1:0] resp;
    logic ok;
    wq.delete();
    s_awaddr[g] = addr; s_awlen[g] = len; s_awvalid[g] = 1; m_awready = 1;
    @(negedge clk);
    tests++; if (m00_axi_awvalid !== 1'b0 || s_awready !== 2'b00) begin fails++; $display("FAIL aw_idle: awvalid=%b awready=%b want 0/00", m00_axi_awvalid, s_awready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({m00_axi_awvalid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awid} !== {1'b1, addr, len, 6'(g)}) begin fails++;
      $display("FAIL aw_pass: v=%b addr=%h len=%0d id=%0d want 1 %h %0d %0d", m00_axi_awvalid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awid, addr, len, g); end
    tests++; if (s_awready !== 2'(1 << g)) begin fails++; $display("FAIL aw_ready: got %b want %b", s_awready, 2'(1 << g)); end
    tests++; if ({m00_axi_awsize, m00_axi_awburst, m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos} !== {3'd3, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0}) begin fails++;
      $display("FAIL aw_static: size=%0d burst=%0d lock=%0d cache=%b prot=%0d qos=%0d", m00_axi_awsize, m00_axi_awburst, m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos); end
    @(posedge clk); #1;
    s_awvalid[g] = 0;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      exp_q.push_back(d);
      s_wdata[g] = d; s_wstrb[g] = 8'hff; s_wlast[g] = (b == int'(len)); s_wvalid[g] = 1;
      if (b == stall_at) begin
        m_wready = 0;
        repeat (stall_n) begin
          @(negedge clk);
          tests++; if (s_wready !== 2'b00 || m00_axi_wvalid !== 1'b1) begin fails++; $display("FAIL w_stall: wready=%b wvalid=%b want 00/1", s_wready, m00_axi_wvalid); end
          @(posedge clk); #1;
        end
      end
      m_wready = 1;
      @(negedge clk);
      tests++; if ({m00_axi_wvalid, m00_axi_wdata, m00_axi_wlast, m00_axi_wid} !== {1'b1, d, b == int'(len), 6'(g)}) begin fails++;
        $display("FAIL w_beat%0d: v=%b data=%h last=%b id=%0d want 1 %h %b %0d", b, m00_axi_wvalid, m00_axi_wdata, m00_axi_wlast, m00_axi_wid, d, b == int'(len), g); end
      tests++; if (s_wready !== 2'(1 << g)) begin fails++; $display("FAIL w_ready: got %b want %b", s_wready, 2'(1 << g)); end
      @(posedge clk); #1;
    end
    s_wvalid[g] = 0; s_wlast[g] = 0; m_wready = 0;
    ok = (wq.size() == exp_q.size());
    for (int i = 0; ok && i < exp_q.size(); i++) ok = (wq[i] === exp_q[i]);
    tests++; if (!ok) begin fails++; $display("FAIL w_beats: transferred %0d beats want %0d (or data differs)", wq.size(), exp_q.size()); end
    resp = 2'($urandom); m_bvalid = 1; m_bid = bid; m_bresp = resp; s_bready[g] = 1;
    @(negedge clk);
    tests++; if (s_bvalid !== 2'(1 << g) || s_bresp[g] !== resp || m00_axi_bready !== 1'b1) begin fails++;
      $display("FAIL b_route: bvalid=%b bresp=%0d bready=%b want %b %0d 1", s_bvalid, s_bresp[g], m00_axi_bready, 2'(1 << g), resp); end
    @(posedge clk); #1;
    m_bvalid = 0; s_bready[g] = 0;
    rr_w = 1'(g);
  endtask

  task automatic read_flow(input int g, input logic [31:0] addr, input logic [3:0] len, input bit chk_idle);
    logic [63:0] d;
    logic [1:0] resp;
    s_araddr[g] = addr; s_arlen[g] = len; s_arvalid[g] = 1; m_arready = 1;
    @(negedge clk);
    tests++; if (m00_axi_arvalid !== 1'b0 || s_arready !== 2'b00) begin fails++; $display("FAIL ar_idle: arvalid=%b arready=%b want 0/00", m00_axi_arvalid, s_arready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({m00_axi_arvalid, m00_axi_araddr, m00_axi_arlen, m00_axi_arid} !== {1'b1, addr, len, 6'(g)}) begin fails++;
      $display("FAIL ar_pass: v=%b addr=%h len=%0d id=%0d want 1 %h %0d %0d", m00_axi_arvalid, m00_axi_araddr, m00_axi_arlen, m00_axi_arid, addr, len, g); end
    tests++; if (s_arready !== 2'(1 << g)) begin fails++; $display("FAIL ar_ready: got %b want %b", s_arready, 2'(1 << g)); end
    tests++; if ({m00_axi_arsize, m00_axi_arburst, m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos} !== {3'd3, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0}) begin fails++;
      $display("FAIL ar_static: size=%0d burst=%0d cache=%b", m00_axi_arsize, m00_axi_arburst, m00_axi_arcache); end
    @(posedge clk); #1;
    s_arvalid[g] = 0; s_rready[g] = 1;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom}; resp = 2'($urandom);
      m_rvalid = 1; m_rdata = d; m_rresp = resp; m_rlast = (b == int'(len)); m_rid = 6'($urandom);
      @(negedge clk);
      tests++; if (s_rvalid !== 2'(1 << g) || s_rdata[g] !== d || s_rresp[g] !== resp || s_rlast[g] !== (b == int'(len)) || m00_axi_rready !== 1'b1) begin fails++;
        $display("FAIL r_beat%0d: rvalid=%b data=%h resp=%0d last=%b rready=%b want %b %h %0d %b 1", b, s_rvalid, s_rdata[g], s_rresp[g], s_rlast[g], m00_axi_rready, 2'(1 << g), d, resp, b == int'(len)); end
      @(posedge clk); #1;
    end
    m_rlast = 0; s_rready[g] = 0;
    rr_r = 1'(g);
    if (chk_idle) begin
      @(negedge clk);
      tests++; if (s_rvalid !== 2'b00) begin fails++; $display("FAIL r_idle: stray rvalid reached requesters %b want 00", s_rvalid); end
      @(posedge clk); #1;
    end
    m_rvalid = 0;
  endtask

  task automatic test_reset();
    aresetn = 0;
    clear_inputs();
    s_awvalid = 2'b11; s_arvalid = 2'b11; m_bvalid = 1; m_rvalid = 1; m_wready = 1;
    @(negedge clk);
    tests++; if ({m00_axi_awvalid, m00_axi_arvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_rready} !== 5'b0) begin fails++;
      $display("FAIL reset_m00: aw/ar/w valid, b/r ready = %b%b%b%b%b want 00000", m00_axi_awvalid, m00_axi_arvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_rready); end
    tests++; if ((s_awready | s_arready | s_wready | s_bvalid | s_rvalid) !== 2'b00) begin fails++;
      $display("FAIL reset_s: awready=%b arready=%b wready=%b bvalid=%b rvalid=%b want 0", s_awready, s_arready, s_wready, s_bvalid, s_rvalid); end
    clear_inputs();
    @(posedge clk); #1 aresetn = 1;
    rr_w = 1; rr_r = 1;
    @(negedge clk);
    tests++; if ({m00_axi_awvalid, m00_axi_arvalid, s_bvalid, s_rvalid} !== 6'b0) begin fails++; $display("FAIL reset_idle: outputs active after release"); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    write_flow(0, 32'h1000, 4'd3, -1, 0, 6'd0);
    @(negedge clk);
    tests++; if (m00_axi_awvalid !== 1'b0 || s_bvalid !== 2'b00 || s_wready !== 2'b00) begin fails++; $display("FAIL single_idle: awvalid=%b bvalid=%b wready=%b want 0", m00_axi_awvalid, s_bvalid, s_wready); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_tie();
    logic [31:0] a [2];
    logic [3:0] l [2];
    int w;
    for (int i = 0; i < 2; i++) begin a[i] = $urandom; l[i] = 4'($urandom_range(0, 3)); s_araddr[i] = a[i]; s_arlen[i] = l[i]; end
    s_arvalid = 2'b11;
    w = pick(2'b11, rr_r);
    read_flow(w, a[w], l[w], 0);
    read_flow(1 - w, a[1 - w], l[1 - w], 1);
  endtask

  task automatic test_write_ties();
    logic [31:0] a [2];
    int w;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin a[i] = $urandom; s_awaddr[i] = a[i]; s_awlen[i] = 4'd1; end
      s_awvalid = 2'b11;
      w = pick(2'b11, rr_w);
      write_flow(w, a[w], 4'd1, -1, 0, 6'($urandom));
      write_flow(1 - w, a[1 - w], 4'd1, -1, 0, 6'($urandom));
    end
  endtask

  task automatic test_random();
    logic [31:0] a [2];
    logic [1:0] req;
    int w;
    for (int it = 0; it < 8; it++) begin
      req = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin a[i] = $urandom; s_awaddr[i] = a[i]; s_awlen[i] = 4'($urandom_range(0, 3)); end
      s_awvalid = req;
      w = pick(req, rr_w);
      write_flow(w, a[w], s_awlen[w], $urandom_range(0, 3), $urandom_range(0, 2), 6'($urandom));
      if (req == 2'b11) write_flow(1 - w, a[1 - w], s_awlen[1 - w], -1, 0, 6'($urandom));
    end
  endtask

  task automatic test_stall();
    write_flow(0, $urandom, 4'd3, 2, 5, 6'd0);
  endtask

  task automatic test_concurrent();
    fork
      write_flow(0, $urandom, 4'd0, -1, 0, 6'd0);
      read_flow(1, $urandom, 4'd7, 1);
    join
  endtask

  task automatic test_reset_mid_burst();
    s_awaddr[0] = 32'h2000; s_awlen[0] = 4'd3; s_awvalid[0] = 1; m_awready = 1; m_wready = 1;
    repeat (2) @(posedge clk);
    #1 s_awvalid[0] = 0;
    for (int b = 0; b < 3; b++) begin
      s_wdata[0] = {$urandom, $urandom}; s_wstrb[0] = 8'hff; s_wvalid[0] = 1;
      if (b < 2) begin @(posedge clk); #1; end
    end
    #1;
    tests++; if (m00_axi_wvalid !== 1'b1 || s_wready !== 2'b01) begin fails++; $display("FAIL mid_burst_pre: wvalid=%b wready=%b want 1/01", m00_axi_wvalid, s_wready); end
    m_bvalid = 1; m_rvalid = 1; s_bready = 2'b11; s_rready = 2'b11;
    aresetn = 0;
    #1;
    tests++; if ({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready} !== 5'b0 || (s_awready | s_wready | s_bvalid | s_arready | s_rvalid) !== 2'b00) begin fails++;
      $display("FAIL mid_burst_reset: m00 aw/w/b/ar/r=%b%b%b%b%b s wready=%b bvalid=%b want 0", m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_rready, s_wready, s_bvalid); end
    clear_inputs();
    @(posedge clk); #1 aresetn = 1;
    rr_w = 1; rr_r = 1;
    write_flow(1, $urandom, 4'd2, -1, 0, 6'd5);
  endtask

  initial begin
    aresetn = 0;
    rr_w = 1; rr_r = 1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_read_tie();
    test_write_ties();
    test_random();
    test_stall();
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
